count_seg_display: RTL

Downstream display/monitor stage for the 4-bit up/down counter. It samples the counter's `Count` and `UpOrDown` outputs and drives a two-digit multiplexed 7-segment display showing `Count` in decimal (0–15), with the leading zero blanked. It also detects wrap-around events and keeps a saturating net wrap tally.

---
 rtl/count_seg_display.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/count_seg_display.sv
// Two-digit muxed 7-seg monitor for a 4-bit up/down counter, plus wrap detection and a saturating net wrap tally.
// Latency: wrap pulse/tally 2 clocks after Count; display on the next frame (<= 2*SCAN_DIV+3 clocks). No backpressure.
module count_seg_display #(
  parameter int SCAN_DIV     = 4,
  parameter bit COMMON_ANODE = 1'b0
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic [3:0] Count,
  input  logic       UpOrDown,
  output logic [6:0] Seg,
  output logic [1:0] An,
  output logic       WrapUp,
  output logic       WrapDown,
  output logic [7:0] WrapCount
);

  typedef enum logic [1:0] {S_UNITS, S_GAP_T, S_TENS, S_GAP_U} state_t;

  localparam logic [15:0] PRESC_MAX = 16'(SCAN_DIV - 1);
  localparam logic [6:0]  POL       = COMMON_ANODE ? 7'h7F : 7'h00;
  localparam logic [6:0]  BLANK     = POL;

  logic [3:0]  count_q, count_prev;
  logic        updown_q;
  logic        wrap_up_d, wrap_down_d;
  state_t      state, state_nxt;
  logic [15:0] presc, presc_nxt;
  logic [3:0]  disp, disp_nxt, units;
  logic        tens;
  logic [6:0]  seg_d;
  logic [1:0]  an_d;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    glyph = 7'h3F;
      4'd1:    glyph = 7'h06;
      4'd2:    glyph = 7'h5B;
      4'd3:    glyph = 7'h4F;
      4'd4:    glyph = 7'h66;
      4'd5:    glyph = 7'h6D;
      4'd6:    glyph = 7'h7D;
      4'd7:    glyph = 7'h07;
      4'd8:    glyph = 7'h7F;
      4'd9:    glyph = 7'h6F;
      default: glyph = 7'h00;
    endcase
  endfunction

  assign wrap_up_d   = (count_prev == 4'd15) && (count_q == 4'd0)  &&  updown_q;
  assign wrap_down_d = (count_prev == 4'd0)  && (count_q == 4'd15) && !updown_q;

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      count_q    <= 4'd0;
      count_prev <= 4'd0;
      updown_q   <= 1'b0;
      WrapUp     <= 1'b0;
      WrapDown   <= 1'b0;
      WrapCount  <= 8'd0;
    end else begin
      count_q    <= Count;
      count_prev <= count_q;
      updown_q   <= UpOrDown;
      WrapUp     <= wrap_up_d;
      WrapDown   <= wrap_down_d;
      // Pulses still fire when the tally is pinned at a rail.
      if (wrap_up_d && (WrapCount != 8'hFF))
        WrapCount <= WrapCount + 8'd1;
      else if (wrap_down_d && (WrapCount != 8'h00))
        WrapCount <= WrapCount - 8'd1;
    end
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state <= S_GAP_U;
      presc <= 16'd0;
      disp  <= 4'd0;
    end else begin
      state <= state_nxt;
      presc <= presc_nxt;
      disp  <= disp_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    presc_nxt = presc + 16'd1;
    case (state)
      S_UNITS: if (presc == PRESC_MAX) begin
        state_nxt = S_GAP_T;
        presc_nxt = 16'd0;
      end
      S_GAP_T: begin
        state_nxt = S_TENS;
        presc_nxt = 16'd0;
      end
      S_TENS: if (presc == PRESC_MAX) begin
        state_nxt = S_GAP_U;
        presc_nxt = 16'd0;
      end
      S_GAP_U: begin
        state_nxt = S_UNITS;
        presc_nxt = 16'd0;
      end
      default: begin
        state_nxt = S_GAP_U;
        presc_nxt = 16'd0;
      end
    endcase
  end

  // Outputs are computed from the next state so they register on the same edge;
  // the frame value is taken from count_q on the edge that loads the latch.
  always_comb begin
    disp_nxt = (state == S_GAP_U) ? count_q : disp;
    tens     = (disp_nxt >= 4'd10);
    units    = tens ? 4'(disp_nxt - 4'd10) : disp_nxt;
    an_d     = 2'b00;
    seg_d    = BLANK;
    case (state_nxt)
      S_UNITS: begin
        an_d  = 2'b01;
        seg_d = glyph(units) ^ POL;
      end
      S_TENS: begin
        an_d  = 2'b10;
        seg_d = tens ? (7'h06 ^ POL) : BLANK;
      end
      default: begin
        an_d  = 2'b00;
        seg_d = BLANK;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      Seg <= BLANK;
      An  <= 2'b00;
    end else begin
      Seg <= seg_d;
      An  <= an_d;
    end
  end

endmodule
